// File: rtl/seq_detect_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_scheduler
// Purpose  : Shares one serial sliding-window sequence detector between two
//            word-level requesters. Each accepted word is preceded by a
//            one-cycle detector clear. The word is then shifted MSB-first into
//            the detector, and the detector's Mealy pulses are counted. One
//            tagged result is produced per word.
// Ports    : clk, rst                     - clock, synchronous active-high reset
//            req0_valid/data/ready        - requester 0 word handshake
//            req1_valid/data/ready        - requester 1 word handshake
//            det_clr, det_in              - clear and serial bit to the detector
//            det_dec                      - detector Mealy match output
//            res_valid, res_id, res_count - one-cycle tagged result
//            busy                         - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_scheduler #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              det_clr,
  output logic              det_in,
  input  logic              det_dec,
  output logic              res_valid,
  output logic              res_id,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy
);

  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic              ptr;      // requester that wins when both are valid
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bitcnt;
  logic              grant0;
  logic              grant1;

  // Round-robin only matters on contention; a lone requester always wins.
  assign grant0 = req0_valid && (!req1_valid || !ptr);
  assign grant1 = req1_valid && (!req0_valid ||  ptr);

  assign req0_ready = !rst && (state == IDLE) && grant0;
  assign req1_ready = !rst && (state == IDLE) && grant1;

  // The detector must clear alongside this block, hence rst is ORed in.
  assign det_clr = rst || (state == CLEAR);
  assign det_in  = (state == SHIFT) ? shreg[WORD_W-1] : 1'b0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_count <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            shreg     <= grant1 ? req1_data : req0_data;
            res_id    <= grant1;
            res_count <= '0;
            ptr       <= !grant1;  // hand priority to the other requester
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          bitcnt <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          shreg  <= shreg << 1;
          bitcnt <= bitcnt + 1'b1;
          // det_dec reacts to the bit presented this cycle, so it is
          // counted before the shift register advances.
          if (det_dec && (res_count != {CNT_W{1'b1}})) begin
            res_count <= res_count + 1'b1;
          end
          if (bitcnt == LAST_BIT) begin
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
